// File: rtl/float_compare_unit_pkg.sv
// Shared types, op encodings and helpers for the float compare unit.
// Optional min/max output is enabled by defining FLOAT_CMP_MINMAX_EN.
package float_cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ = 3'd0,
    OP_NE = 3'd1,
    OP_LT = 3'd2,
    OP_LE = 3'd3,
    OP_GT = 3'd4,
    OP_GE = 3'd5
  } fc_op_e;

  localparam int FC_DATA_W = 32;
  localparam int FC_EXP_W  = 8;
  localparam int FC_MAN_W  = FC_DATA_W - FC_EXP_W - 1;

  localparam logic [FC_DATA_W-1:0] FC_QNAN =
    {1'b0, {FC_EXP_W{1'b1}}, 1'b1, {(FC_MAN_W-1){1'b0}}};

  typedef struct packed {
    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic a_lt_b;
    logic a_eq_b;
  } fc_flags_t;

  function automatic logic fc_is_nan(
    input logic [63:0] x,
    input int          dw,
    input int          ew
  );
    logic [63:0] e_mask;
    logic [63:0] m_mask;
    m_mask = (64'd1 << (dw - ew - 1)) - 64'd1;
    e_mask = (64'd1 << ew) - 64'd1;
    return (((x >> (dw - ew - 1)) & e_mask) == e_mask)
        && ((x & m_mask) != 64'd0);
  endfunction

  // Unordered pairs are false for every op except NE.
  function automatic logic fc_decode(
    input logic [2:0] op,
    input fc_flags_t  f
  );
    logic un;
    logic r;
    un = f.a_nan | f.b_nan;
    case (op)
      OP_EQ:   r = !un && f.a_eq_b;
      OP_NE:   r = un || !f.a_eq_b;
      OP_LT:   r = !un && f.a_lt_b;
      OP_LE:   r = !un && (f.a_lt_b || f.a_eq_b);
      OP_GT:   r = !un && !f.a_lt_b && !f.a_eq_b;
      OP_GE:   r = !un && !f.a_lt_b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/float_compare_unit_if.sv
// Stream/control bundle of the float compare unit.
// out2 exists only when FLOAT_CMP_MINMAX_EN is defined.
interface float_compare_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              running;
  logic              run;
  logic [2:0]        op;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] out0;
  logic [CNT_W-1:0]  out1;
`ifdef FLOAT_CMP_MINMAX_EN
  logic [DATA_W-1:0] out2;

  modport master (
    output running, run, op, in0, in1,
    input  out0, out1, out2
  );
  modport slave (
    input  running, run, op, in0, in1,
    output out0, out1, out2
  );
`else
  modport master (
    output running, run, op, in0, in1,
    input  out0, out1
  );
  modport slave (
    input  running, run, op, in0, in1,
    output out0, out1
  );
`endif
endinterface

// File: rtl/float_compare_unit_core.sv
// Combinational IEEE-754 classify and ordering of two operands.
// Flags only; op selection happens downstream.
module float_cmp_core
  import float_cmp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_nan,
  output logic              b_nan,
  output logic              both_zero,
  output logic              a_lt_b,
  output logic              a_eq_b
);

  logic [DATA_W-2:0] a_mag;
  logic [DATA_W-2:0] b_mag;
  logic              a_sgn;
  logic              b_sgn;

  assign a_sgn = a[DATA_W-1];
  assign b_sgn = b[DATA_W-1];
  assign a_mag = a[DATA_W-2:0];
  assign b_mag = b[DATA_W-2:0];

  assign a_nan = fc_is_nan(64'(a), DATA_W, EXP_W);
  assign b_nan = fc_is_nan(64'(b), DATA_W, EXP_W);
  assign both_zero = (a_mag == '0) && (b_mag == '0);

  // Sign-magnitude order: magnitude compare flips for negatives.
  always_comb begin
    a_eq_b = 1'b0;
    a_lt_b = 1'b0;
    if (both_zero) begin
      a_eq_b = 1'b1;
    end else if (a_sgn != b_sgn) begin
      a_lt_b = a_sgn;
    end else begin
      a_eq_b = (a_mag == b_mag);
      a_lt_b = a_sgn ? (a_mag > b_mag) : (a_mag < b_mag);
    end
  end

endmodule

// File: rtl/float_compare_unit.sv
// Pipelined six-op float comparator with mask output and true counter.
// Define FLOAT_CMP_MINMAX_EN to add the min/max output out2.
module float_compare_unit
  import float_cmp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  float_compare_unit_if.slave bus
);

  localparam int DLY = (LATENCY == 1) ? 1 : LATENCY - 1;

  logic [2:0] op_q;
  logic [2:0] eff_op;
  fc_flags_t  flg;

  fc_flags_t  src_flg;
  logic [2:0] src_op;
  logic       src_vld;
  logic       res_d;

  logic [DLY-1:0] res_q;
  logic [DLY-1:0] vld_q;
  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign eff_op = bus.run ? bus.op : op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          op_q <= OP_EQ;
    else if (bus.run) op_q <= bus.op;
  end

  float_cmp_core #(
    .DATA_W (DATA_W),
    .EXP_W  (EXP_W)
  ) u_core (
    .a         (bus.in0),
    .b         (bus.in1),
    .a_nan     (flg.a_nan),
    .b_nan     (flg.b_nan),
    .both_zero (flg.both_zero),
    .a_lt_b    (flg.a_lt_b),
    .a_eq_b    (flg.a_eq_b)
  );

`ifdef FLOAT_CMP_MINMAX_EN
  localparam int MAN_W = DATA_W - EXP_W - 1;
  localparam logic [DATA_W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] mm_d;
  logic [DATA_W-1:0] mm_q [DLY];
`endif

  generate
    if (LATENCY == 1) begin : g_direct
      assign src_flg = flg;
      assign src_op  = eff_op;
      assign src_vld = bus.running;
`ifdef FLOAT_CMP_MINMAX_EN
      assign src_a = bus.in0;
      assign src_b = bus.in1;
`endif
    end else begin : g_stage1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          src_flg <= '0;
          src_op  <= OP_EQ;
          src_vld <= 1'b0;
        end else begin
          src_flg <= flg;
          src_op  <= eff_op;
          src_vld <= bus.running;
        end
      end
`ifdef FLOAT_CMP_MINMAX_EN
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          src_a <= '0;
          src_b <= '0;
        end else begin
          src_a <= bus.in0;
          src_b <= bus.in1;
        end
      end
`endif
    end
  endgenerate

  always_comb res_d = fc_decode(src_op, src_flg);

`ifdef FLOAT_CMP_MINMAX_EN
  // A NaN input defers to the other operand; -0 sorts below +0.
  always_comb begin
    logic [DATA_W-1:0] mn;
    logic [DATA_W-1:0] mx;
    if (src_flg.both_zero) begin
      mn = src_a[DATA_W-1] ? src_a : src_b;
      mx = src_a[DATA_W-1] ? src_b : src_a;
    end else begin
      mn = src_flg.a_lt_b ? src_a : src_b;
      mx = src_flg.a_lt_b ? src_b : src_a;
    end
    if (src_flg.a_nan && src_flg.b_nan)
      mm_d = QNAN;
    else if (src_flg.a_nan)
      mm_d = src_b;
    else if (src_flg.b_nan)
      mm_d = src_a;
    else if (src_op == OP_LT || src_op == OP_LE)
      mm_d = mn;
    else
      mm_d = mx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) mm_q[i] <= '0;
    end else begin
      mm_q[0] <= mm_d;
      for (int i = 1; i < DLY; i++) mm_q[i] <= mm_q[i-1];
    end
  end

  assign bus.out2 = mm_q[DLY-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= '0;
    end else begin
      res_q[0] <= res_d;
      vld_q[0] <= src_vld;
      for (int i = 1; i < DLY; i++) begin
        res_q[i] <= res_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign hit = vld_q[DLY-1] & res_q[DLY-1];

  // run wins over a result leaving the pipe in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (bus.run)          cnt <= '0;
    else if (hit && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign bus.out0 = {DATA_W{res_q[DLY-1]}};
  assign bus.out1 = cnt;

endmodule

// File: tb/tb_float_compare_unit.sv
// Random + directed bench for float_compare_unit at LATENCY 2 and 4.
// Reference compares operands as real numbers.
module tb_float_compare_unit;
  import float_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  float_compare_unit_if #(.DATA_W(32), .CNT_W(16)) bus ();
  float_compare_unit_if #(.DATA_W(32), .CNT_W(3))  bus4 ();

  float_compare_unit #(
    .DATA_W(32), .EXP_W(8), .LATENCY(2), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  float_compare_unit #(
    .DATA_W(32), .EXP_W(8), .LATENCY(4), .CNT_W(3)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct {
    bit v;
    bit r;
  } smp_t;

  smp_t hist[$];
  int   cnt[2];
  int   opq;
  int   lat[2]  = '{2, 4};
  int   cmax[2] = '{65535, 7};
  int   n_chk   = 0;
  int   n_pass  = 0;

  logic [31:0] specials[10] = '{
    32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7F800000,
    32'hFF800000, 32'h3F800000, 32'hBF800000, 32'h40000000,
    32'hC0000000, 32'h7F800001
  };

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real f2r(logic [31:0] x);
    real m;
    real v;
    int  e;
    e = int'(x[30:23]);
    m = real'(x[22:0]) / 8388608.0;
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = m * (2.0 ** (-126));
    else             v = (1.0 + m) * (2.0 ** (e - 127));
    return x[31] ? -v : v;
  endfunction

  function automatic bit ref_cmp(int op, logic [31:0] a, logic [31:0] b);
    real x;
    real y;
    if (is_nan(a) || is_nan(b)) return op == 1;
    x = f2r(a);
    y = f2r(b);
    case (op)
      0: return x == y;
      1: return x != y;
      2: return x < y;
      3: return x <= y;
      4: return x > y;
      5: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_out0(int d);
    if (hist.size() >= lat[d] && hist[lat[d]-1].r) return 32'hFFFFFFFF;
    return 32'h0;
  endfunction

  task automatic model_clear();
    hist.delete();
    cnt = '{0, 0};
    opq = 0;
  endtask

  task automatic model_step();
    smp_t s;
    int   eff;
    eff = bus.run ? int'(bus.op) : opq;
    s.v = bus.running;
    s.r = ref_cmp(eff, bus.in0, bus.in1);
    hist.push_front(s);
    if (hist.size() > 6) void'(hist.pop_back());
    for (int d = 0; d < 2; d++) begin
      if (bus.run) cnt[d] = 0;
      else if (hist.size() > lat[d] && hist[lat[d]].v
               && hist[lat[d]].r && cnt[d] < cmax[d])
        cnt[d]++;
    end
    if (bus.run) opq = int'(bus.op);
  endtask

  task automatic check_all();
    chk("out0_L2", bus.out0, exp_out0(0));
    chk("out1_L2", 32'(bus.out1), cnt[0]);
    chk("out0_L4", bus4.out0, exp_out0(1));
    chk("out1_L4", 32'(bus4.out1), cnt[1]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) model_step();
    check_all();
  endtask

  task automatic drive(bit rn, int o, logic [31:0] a, logic [31:0] b,
                       bit rung);
    bus.run      = rn;
    bus4.run     = rn;
    bus.op       = 3'(o);
    bus4.op      = 3'(o);
    bus.in0      = a;
    bus4.in0     = a;
    bus.in1      = b;
    bus4.in1     = b;
    bus.running  = rung;
    bus4.running = rung;
  endtask

  function automatic logic [31:0] rnd_f();
    logic [31:0] x;
    case ($urandom_range(0, 3))
      0: x = specials[$urandom_range(0, 9)];
      1: x = $urandom;
      2: x = {1'($urandom), 8'(126 + $urandom_range(0, 2)),
              23'($urandom_range(0, 3))};
      default: x = {1'($urandom), 8'($urandom_range(0, 1)),
                    23'($urandom_range(0, 2))};
    endcase
    return x;
  endfunction

  task automatic drive_rand();
    logic [31:0] a;
    logic [31:0] b;
    a = rnd_f();
    case ($urandom_range(0, 4))
      0:       b = a;
      1:       b = a ^ 32'h80000000;
      default: b = rnd_f();
    endcase
    drive($urandom_range(0, 15) == 0, $urandom_range(0, 7), a, b,
          $urandom_range(0, 3) != 0);
  endtask

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    bit          r;
  } vec_t;

  vec_t tbl[15] = '{
    '{5, 32'h40000000, 32'h3F800000, 1'b1},
    '{0, 32'h80000000, 32'h00000000, 1'b1},
    '{2, 32'h80000000, 32'h00000000, 1'b0},
    '{1, 32'h7FC00000, 32'h3F800000, 1'b1},
    '{0, 32'h7FC00000, 32'h3F800000, 1'b0},
    '{2, 32'h7FC00000, 32'h3F800000, 1'b0},
    '{5, 32'h7FC00000, 32'h3F800000, 1'b0},
    '{2, 32'hC0000000, 32'hBF800000, 1'b1},
    '{2, 32'hBF800000, 32'hC0000000, 1'b0},
    '{2, 32'hFF800000, 32'h3F800000, 1'b1},
    '{2, 32'hFF800000, 32'hC7000000, 1'b1},
    '{4, 32'h7F800000, 32'h7F7FFFFF, 1'b1},
    '{3, 32'h00000000, 32'h80000000, 1'b1},
    '{6, 32'h3F800000, 32'h3F800000, 1'b0},
    '{4, 32'h3F800000, 32'h7F800001, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_clear();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // GE 2.0 vs 1.0: mask two cycles later, count one cycle after.
    drive(1, 5, 32'h40000000, 32'h3F800000, 1);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("t1_out0", bus.out0, 32'hFFFFFFFF);
    step();
    chk("t1_out1", 32'(bus.out1), 1);

    foreach (tbl[i]) begin
      drive(1, tbl[i].op, tbl[i].a, tbl[i].b, 1);
      step();
      drive(0, 0, 0, 0, 0);
      step();
      chk($sformatf("tbl%0d", i), bus.out0,
          tbl[i].r ? 32'hFFFFFFFF : 32'h0);
    end

    // Ten trues counted, run lands as the eleventh exits.
    drive(1, 4, 32'h40000000, 32'h3F800000, 1);
    step();
    repeat (10) begin
      drive(0, 4, 32'h40000000, 32'h3F800000, 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();
    chk("t5_pre_L2", 32'(bus.out1), 10);
    chk("t5_sat_L4", 32'(bus4.out1), 7);
    drive(1, 4, 0, 0, 0);
    step();
    chk("t5_run_L2", 32'(bus.out1), 0);
    chk("t5_run_L4", 32'(bus4.out1), 0);
    drive(0, 0, 0, 0, 0);
    repeat (5) step();

    repeat (250) begin
      drive_rand();
      step();
    end

    // Asynchronous reset with full pipes.
    drive(1, 5, 32'h40000000, 32'h3F800000, 1);
    step();
    repeat (6) begin
      drive(0, 5, 32'h40000000, 32'h3F800000, 1);
      step();
    end
    chk("t6_pre_L4", bus4.out0, 32'hFFFFFFFF);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    chk("t6_out0_L4", bus4.out0, 32'h0);
    chk("t6_out1_L4", 32'(bus4.out1), 0);
    chk("t6_out0_L2", bus.out0, 32'h0);
    chk("t6_out1_L2", 32'(bus.out1), 0);
    step();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 5, 32'h40000000, 32'h3F800000, 1);
    repeat (6) step();

    repeat (150) begin
      drive_rand();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
